// File: rtl/spu_issue_scoreboard.sv
// Dual-issue hazard scoreboard and issue sequencer for the SPU pipeline.
// Optional build macro: SPU_SB_FWD_EN (treat a register as clear one cycle early for WB->ID forwarding).
module spu_issue_scoreboard #(
    parameter int NUM_REGS = 128,
    parameter int LAT      = 8,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst0_valid,
    input  logic [6:0]  inst0_ra,
    input  logic [6:0]  inst0_rb,
    input  logic [6:0]  inst0_rc,
    input  logic [2:0]  inst0_src_used,
    input  logic [6:0]  inst0_rt,
    input  logic        inst0_wr,
    input  logic        inst1_valid,
    input  logic [6:0]  inst1_ra,
    input  logic [6:0]  inst1_rb,
    input  logic [6:0]  inst1_rc,
    input  logic [2:0]  inst1_src_used,
    input  logic [6:0]  inst1_rt,
    input  logic        inst1_wr,
    input  logic        flush,
    output logic        issue0,
    output logic        issue1,
    output logic        pc_enable,
    output logic        busy_any,
    output logic [15:0] stall_count
);

    localparam int AW = 7;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(LAT);

    typedef enum logic [0:0] {
        PAIR       = 1'b0,
        SLOT1_ONLY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  busy_r     [NUM_REGS];
    logic [CNT_W-1:0]  busy_nxt_s [NUM_REGS];
    logic              busy_any_r;
    logic              busy_any_nxt_s;
    logic [15:0]       stall_cnt_r;
    logic              issue0_s;
    logic              issue1_s;
    logic              pc_en_s;
    logic              rdy0_s;
    logic              rdy1_s;
    logic              raw_s;
    logic              waw_s;

    // A pending write no longer blocks readers once its counter is low enough.
    function automatic logic reg_clear(input logic [CNT_W-1:0] cnt);
`ifdef SPU_SB_FWD_EN
        return (cnt <= CNT_ONE);
`else
        return (cnt == CNT_ZERO);
`endif
    endfunction

    function automatic logic slot_ready(input logic [2:0] used,
                                        input logic [CNT_W-1:0] cnt_a,
                                        input logic [CNT_W-1:0] cnt_b,
                                        input logic [CNT_W-1:0] cnt_c);
        return (~used[0] | reg_clear(cnt_a)) &
               (~used[1] | reg_clear(cnt_b)) &
               (~used[2] | reg_clear(cnt_c));
    endfunction

    // Per-slot readiness and intra-pair dependency detection.
    always_comb begin
        rdy0_s = slot_ready(inst0_src_used, busy_r[inst0_ra], busy_r[inst0_rb], busy_r[inst0_rc]);
        rdy1_s = slot_ready(inst1_src_used, busy_r[inst1_ra], busy_r[inst1_rb], busy_r[inst1_rc]);
        raw_s  = inst0_wr & ((inst1_src_used[0] & (inst1_ra == inst0_rt)) |
                             (inst1_src_used[1] & (inst1_rb == inst0_rt)) |
                             (inst1_src_used[2] & (inst1_rc == inst0_rt)));
        waw_s  = inst0_wr & inst1_wr & (inst0_rt == inst1_rt);
    end

    // Issue decision, fetch enable and sequencer next state.
    always_comb begin
        issue0_s    = 1'b0;
        issue1_s    = 1'b0;
        pc_en_s     = 1'b1;
        state_nxt_s = state_r;
        if (!reset) begin
            state_nxt_s = PAIR;
        end else begin
            case (state_r)
                PAIR: begin
                    issue0_s = inst0_valid & rdy0_s & ~flush;
                    issue1_s = issue0_s & inst1_valid & rdy1_s & ~raw_s & ~waw_s;
                    pc_en_s  = flush | ((~inst0_valid | issue0_s) & (~inst1_valid | issue1_s));
                    if (issue0_s & inst1_valid & ~issue1_s) begin
                        state_nxt_s = SLOT1_ONLY;
                    end else begin
                        state_nxt_s = PAIR;
                    end
                end
                SLOT1_ONLY: begin
                    issue1_s = inst1_valid & rdy1_s & ~flush;
                    pc_en_s  = flush | ~inst1_valid | issue1_s;
                    if (issue1_s | flush) begin
                        state_nxt_s = PAIR;
                    end else begin
                        state_nxt_s = SLOT1_ONLY;
                    end
                end
                default: begin
                    state_nxt_s = PAIR;
                end
            endcase
        end
    end

    // Busy counters: a new write reloads LAT, otherwise count down toward zero.
    always_comb begin
        busy_any_nxt_s = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((issue0_s & inst0_wr & (inst0_rt == AW'(r))) |
                (issue1_s & inst1_wr & (inst1_rt == AW'(r)))) begin
                busy_nxt_s[r] = CNT_LAT;
            end else if (busy_r[r] != CNT_ZERO) begin
                busy_nxt_s[r] = busy_r[r] - CNT_ONE;
            end else begin
                busy_nxt_s[r] = CNT_ZERO;
            end
            busy_any_nxt_s = busy_any_nxt_s | (busy_nxt_s[r] != CNT_ZERO);
        end
    end

    // Counter array storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_r[r] <= CNT_ZERO;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_r[r] <= busy_nxt_s[r];
            end
        end
    end

    // Sequencer state, busy summary and saturating stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= PAIR;
            busy_any_r  <= 1'b0;
            stall_cnt_r <= 16'h0000;
        end else begin
            state_r    <= state_nxt_s;
            busy_any_r <= busy_any_nxt_s;
            if (!pc_en_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign issue0      = issue0_s;
    assign issue1      = issue1_s;
    assign pc_enable   = pc_en_s;
    assign busy_any    = busy_any_r;
    assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed and randomized bench for spu_issue_scoreboard; reference model tracks write timestamps.
module tb_spu_issue_scoreboard;

    localparam int LAT = 8;
`ifdef SPU_SB_FWD_EN
    localparam int EXP_DIST = LAT;
    localparam longint FWD_ADJ = 1;
`else
    localparam int EXP_DIST = LAT + 1;
    localparam longint FWD_ADJ = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i0_valid, i0_wr, i1_valid, i1_wr, flush;
    logic [6:0]  i0_ra, i0_rb, i0_rc, i0_rt, i1_ra, i1_rb, i1_rc, i1_rt;
    logic [2:0]  i0_used, i1_used;
    logic        issue0, issue1, pc_enable, busy_any;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    // model: cycle at which each register's pending write fully retires
    longint     m_cyc = 0;
    longint     busy_until [128];
    bit         m_split = 1'b0;
    logic [15:0] m_stall = 16'h0000;
    bit         e_i0, e_i1, e_pc, e_any, m_last_pc = 1'b1;
    bit         seen_i0, seen_i1, seen_pc;

    spu_issue_scoreboard #(.NUM_REGS(128), .LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .inst0_valid(i0_valid), .inst0_ra(i0_ra), .inst0_rb(i0_rb), .inst0_rc(i0_rc),
        .inst0_src_used(i0_used), .inst0_rt(i0_rt), .inst0_wr(i0_wr),
        .inst1_valid(i1_valid), .inst1_ra(i1_ra), .inst1_rb(i1_rb), .inst1_rc(i1_rc),
        .inst1_src_used(i1_used), .inst1_rt(i1_rt), .inst1_wr(i1_wr),
        .flush(flush), .issue0(issue0), .issue1(issue1), .pc_enable(pc_enable),
        .busy_any(busy_any), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit clr(input logic [6:0] r);
        return m_cyc >= (busy_until[r] - FWD_ADJ);
    endfunction

    function automatic bit src_ok(input logic [2:0] u, input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        return (!u[0] || clr(a)) && (!u[1] || clr(b)) && (!u[2] || clr(c));
    endfunction

    function automatic void model_eval();
        bit raw, waw;
        if (!reset) begin
            for (int r = 0; r < 128; r++) busy_until[r] = 0;
            m_split = 1'b0;
            m_stall = 16'h0000;
        end
        raw = i0_wr && ((i1_used[0] && i1_ra == i0_rt) || (i1_used[1] && i1_rb == i0_rt) ||
                        (i1_used[2] && i1_rc == i0_rt));
        waw = i0_wr && i1_wr && (i0_rt == i1_rt);
        if (!m_split) begin
            e_i0 = i0_valid && src_ok(i0_used, i0_ra, i0_rb, i0_rc) && !flush;
            e_i1 = e_i0 && i1_valid && src_ok(i1_used, i1_ra, i1_rb, i1_rc) && !raw && !waw;
            e_pc = flush || ((!i0_valid || e_i0) && (!i1_valid || e_i1));
        end else begin
            e_i0 = 1'b0;
            e_i1 = i1_valid && src_ok(i1_used, i1_ra, i1_rb, i1_rc) && !flush;
            e_pc = flush || !i1_valid || e_i1;
        end
        if (!reset) begin
            e_i0 = 1'b0; e_i1 = 1'b0; e_pc = 1'b1;
        end
        e_any = 1'b0;
        for (int r = 0; r < 128; r++) if (m_cyc < busy_until[r]) e_any = 1'b1;
        m_last_pc = e_pc;
    endfunction

    function automatic void model_commit();
        if (reset) begin
            if (e_i0 && i0_wr) busy_until[i0_rt] = m_cyc + LAT + 1;
            if (e_i1 && i1_wr) busy_until[i1_rt] = m_cyc + LAT + 1;
            if (!e_pc && m_stall != 16'hFFFF) m_stall = m_stall + 16'h0001;
            if (flush) m_split = 1'b0;
            else if (!m_split && e_i0 && i1_valid && !e_i1) m_split = 1'b1;
            else if (m_split && e_i1) m_split = 1'b0;
        end
        m_cyc++;
    endfunction

    task automatic run_cycle();
        #1;
        model_eval();
        seen_i0 = issue0; seen_i1 = issue1; seen_pc = pc_enable;
        chk("issue0", {31'd0, issue0}, {31'd0, e_i0});
        chk("issue1", {31'd0, issue1}, {31'd0, e_i1});
        chk("pc_enable", {31'd0, pc_enable}, {31'd0, e_pc});
        chk("busy_any", {31'd0, busy_any}, {31'd0, e_any});
        chk("stall_count", {16'd0, stall_count}, {16'd0, m_stall});
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [6:0] ra, input logic [2:0] u, input logic [6:0] rt, input logic wr);
        i0_valid = v; i0_ra = ra; i0_rb = 7'd0; i0_rc = 7'd0; i0_used = u; i0_rt = rt; i0_wr = wr;
    endtask

    task automatic set1(input logic v, input logic [6:0] ra, input logic [2:0] u, input logic [6:0] rt, input logic wr);
        i1_valid = v; i1_ra = ra; i1_rb = 7'd0; i1_rc = 7'd0; i1_used = u; i1_rt = rt; i1_wr = wr;
    endtask

    task automatic idle(input int n);
        set0(1'b0, 7'd0, 3'b000, 7'd0, 1'b0);
        set1(1'b0, 7'd0, 3'b000, 7'd0, 1'b0);
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    initial begin
        int n;
        logic [15:0] base;
        for (int r = 0; r < 128; r++) busy_until[r] = 0;
        reset = 1'b0;
        flush = 1'b0;
        set0(1'b1, 7'd1, 3'b001, 7'd3, 1'b1);
        set1(1'b1, 7'd2, 3'b001, 7'd4, 1'b1);
        @(negedge clk);
        run_cycle();
        chk("rst_issue0", {31'd0, seen_i0}, 32'd0);
        chk("rst_pc", {31'd0, seen_pc}, 32'd1);
        run_cycle();

        // independent pair after reset release
        reset = 1'b1;
        run_cycle();
        chk("indep_i0", {31'd0, seen_i0}, 32'd1);
        chk("indep_i1", {31'd0, seen_i1}, 32'd1);
        idle(LAT + 2);

        // back-to-back RAW across cycles
        base = m_stall;
        set0(1'b1, 7'd0, 3'b000, 7'd5, 1'b1);
        run_cycle();
        set0(1'b1, 7'd5, 3'b001, 7'd6, 1'b1);
        n = 0;
        do begin run_cycle(); n++; end while (!seen_i0 && n < 20);
        chk("raw_dist", n, EXP_DIST);
        chk("raw_stalls", {16'd0, stall_count}, {16'd0, base + 16'(EXP_DIST - 1)});
        idle(LAT + 2);

        // intra-pair RAW splits the pair
        set0(1'b1, 7'd0, 3'b000, 7'd7, 1'b1);
        set1(1'b1, 7'd7, 3'b001, 7'd8, 1'b1);
        run_cycle();
        chk("pair_raw_i0", {31'd0, seen_i0}, 32'd1);
        chk("pair_raw_i1", {31'd0, seen_i1}, 32'd0);
        n = 0;
        do begin run_cycle(); n++; end while (!seen_i1 && n < 20);
        chk("pair_raw_dist", n, EXP_DIST);
        chk("pair_raw_pc", {31'd0, seen_pc}, 32'd1);
        idle(LAT + 2);

        // flush while waiting on slot 1
        set0(1'b1, 7'd0, 3'b000, 7'd10, 1'b1);
        set1(1'b1, 7'd10, 3'b001, 7'd11, 1'b1);
        run_cycle();
        flush = 1'b1;
        run_cycle();
        chk("flush_i1", {31'd0, seen_i1}, 32'd0);
        chk("flush_pc", {31'd0, seen_pc}, 32'd1);
        flush = 1'b0;
        set0(1'b1, 7'd11, 3'b001, 7'd12, 1'b0);
        set1(1'b0, 7'd0, 3'b000, 7'd0, 1'b0);
        run_cycle();
        chk("flush_no_set", {31'd0, seen_i0}, 32'd1);
        idle(LAT + 2);

        // reset mid-operation discards pending hazards
        set0(1'b1, 7'd0, 3'b000, 7'd9, 1'b1);
        run_cycle();
        idle(4);
        reset = 1'b0;
        run_cycle();
        reset = 1'b1;
        set0(1'b1, 7'd9, 3'b001, 7'd13, 1'b0);
        run_cycle();
        chk("rst_mid_issue", {31'd0, seen_i0}, 32'd1);

        // randomized traffic; fetch holds inputs while stalled
        for (int k = 0; k < 400; k++) begin
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 99) == 0) reset = 1'b0;
            if (m_last_pc) begin
                i0_valid = ($urandom_range(0, 9) != 0);
                i0_ra = 7'($urandom_range(0, 15)); i0_rb = 7'($urandom_range(0, 15));
                i0_rc = 7'($urandom_range(0, 15)); i0_used = 3'($urandom_range(0, 7));
                i0_rt = 7'($urandom_range(0, 15)); i0_wr = ($urandom_range(0, 3) != 0);
                i1_valid = ($urandom_range(0, 9) < 7);
                i1_ra = 7'($urandom_range(0, 15)); i1_rb = 7'($urandom_range(0, 15));
                i1_rc = 7'($urandom_range(0, 15)); i1_used = 3'($urandom_range(0, 7));
                i1_rt = 7'($urandom_range(0, 15)); i1_wr = ($urandom_range(0, 3) != 0);
            end
            flush = ($urandom_range(0, 19) == 0);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
